autobus_checker: RTL and testbench

//  Sink and checker for the auto bus testpattern. It sits directly downstream of the pattern generator:

---
 rtl/autobus_pkg.sv | 30 +++
 rtl/autobus_rdy_gen.sv | 41 ++++
 rtl/autobus_checker.sv | 170 +++++++++++++++++
 tb/tb_autobus_checker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/autobus_pkg.sv
// Shared definitions for the auto bus testpattern checker.
// Covers FSM states, err_flags bit positions, bp_mode codes and the rdy LFSR step.
package autobus_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  localparam int ERR_DAT = 0;
  localparam int ERR_SOP = 1;
  localparam int ERR_EOP = 2;
  localparam int ERR_SOF = 3;
  localparam int ERR_EOF = 4;
  localparam int ERR_W   = 5;

  localparam logic [1:0] BP_ALWAYS = 2'd0;
  localparam logic [1:0] BP_TOGGLE = 2'd1;
  localparam logic [1:0] BP_LFSR   = 2'd2;
  localparam logic [1:0] BP_STALL  = 2'd3;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Right-shifting Galois step; the bit shifted out selects the feedback mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/autobus_rdy_gen.sv
// Backpressure source: turns bp_mode into a registered rdy toward the generator.
// The LFSR free-runs in every mode, so switching into LFSR mode picks up mid-sequence.
module autobus_rdy_gen
  import autobus_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bp_mode,
  output logic       rdy
);

  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr_q, lfsr_d;
  logic        rdy_q, rdy_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
    case (bp_mode)
      BP_ALWAYS: rdy_d = 1'b1;
      BP_TOGGLE: rdy_d = ~rdy_q;
      BP_LFSR:   rdy_d = lfsr_q[0];
      default:   rdy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      rdy_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      rdy_q  <= rdy_d;
    end
  end

  assign rdy = rdy_q;

endmodule

// File: rtl/autobus_checker.sv
// Sink and checker for the auto bus testpattern: drives rdy, tracks packet/frame
// alignment, counts good packets/frames and records framing/data errors.
module autobus_checker
  import autobus_pkg::*;
#(
  parameter int          DWID      = 16,
  parameter int          CNTW      = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      sop_len,
  input  logic [15:0]      sof_len,
  input  logic [1:0]       bp_mode,
  input  logic             clr,
  input  logic             sop,
  input  logic             eop,
  input  logic             sof,
  input  logic             eof,
  input  logic [DWID-1:0]  dat,
  input  logic             dav,
  output logic             rdy,
  output logic             locked,
  output logic [CNTW-1:0]  pkt_cnt,
  output logic [CNTW-1:0]  frm_cnt,
  output logic [15:0]      err_cnt,
  output logic [ERR_W-1:0] err_flags
);

  state_e           state_q, state_d;
  logic [15:0]      exp_idx_q, exp_idx_d;
  logic [15:0]      pkt_idx_q, pkt_idx_d;
  logic [15:0]      l_pkt_q, l_pkt_d;
  logic [15:0]      l_frm_q, l_frm_d;
  logic             locked_q, locked_d;
  logic [CNTW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNTW-1:0]  frm_cnt_q, frm_cnt_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] err_flags_q, err_flags_d;

  logic             beat, chk, zero_len;
  logic [15:0]      lp, lf, idx, pidx;
  logic [ERR_W-1:0] err;

  autobus_rdy_gen #(.LFSR_SEED(LFSR_SEED)) u_rdy_gen (
    .clk     (clk),
    .rst     (rst),
    .bp_mode (bp_mode),
    .rdy     (rdy)
  );

  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    pkt_idx_d   = pkt_idx_q;
    l_pkt_d     = l_pkt_q;
    l_frm_d     = l_frm_q;
    locked_d    = locked_q;
    pkt_cnt_d   = pkt_cnt_q;
    frm_cnt_d   = frm_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_flags_d = err_flags_q;
    beat        = dav & rdy;
    zero_len    = (sop_len == 16'd0) || (sof_len == 16'd0);
    chk         = 1'b0;
    lp          = l_pkt_q;
    lf          = l_frm_q;
    idx         = exp_idx_q;
    pidx        = pkt_idx_q;
    err         = '0;

    if (beat) begin
      case (state_q)
        ST_HUNT: begin
          // The aligning beat is itself checked against the freshly latched lengths.
          if (sop && sof && !zero_len) begin
            chk  = 1'b1;
            lp   = sop_len;
            lf   = sof_len;
            idx  = 16'd0;
            pidx = 16'd0;
          end
        end
        ST_IN_PKT: chk = 1'b1;
        default: begin
          chk = 1'b1;
          idx = 16'd0;
          if (sop && sof && pkt_idx_q == 16'd0) begin
            if (zero_len) begin
              chk      = 1'b0;
              state_d  = ST_HUNT;
              locked_d = 1'b0;
            end else begin
              lp = sop_len;
              lf = sof_len;
            end
          end
        end
      endcase
    end

    if (chk) begin
      err[ERR_DAT] = dat != DWID'(idx);
      err[ERR_SOP] = sop != (idx == 16'd0);
      err[ERR_EOP] = eop != (idx == lp - 16'd1);
      err[ERR_SOF] = sof != (sop && pidx == 16'd0);
      err[ERR_EOF] = eof != (eop && pidx == lf - 16'd1);
      if (|err) begin
        err_flags_d = err_flags_q | err;
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        locked_d = 1'b0;
        state_d  = ST_HUNT;
      end else begin
        l_pkt_d  = lp;
        l_frm_d  = lf;
        locked_d = 1'b1;
        if (eop) begin
          pkt_cnt_d = pkt_cnt_q + CNTW'(1);
          if (eof) frm_cnt_d = frm_cnt_q + CNTW'(1);
          pkt_idx_d = (pidx == lf - 16'd1) ? 16'd0 : pidx + 16'd1;
          state_d   = ST_GAP;
        end else begin
          exp_idx_d = idx + 16'd1;
          pkt_idx_d = pidx;
          state_d   = ST_IN_PKT;
        end
      end
    end

    if (clr) begin
      pkt_cnt_d   = '0;
      frm_cnt_d   = '0;
      err_cnt_d   = '0;
      err_flags_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      exp_idx_q   <= '0;
      pkt_idx_q   <= '0;
      l_pkt_q     <= '0;
      l_frm_q     <= '0;
      locked_q    <= 1'b0;
      pkt_cnt_q   <= '0;
      frm_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      pkt_idx_q   <= pkt_idx_d;
      l_pkt_q     <= l_pkt_d;
      l_frm_q     <= l_frm_d;
      locked_q    <= locked_d;
      pkt_cnt_q   <= pkt_cnt_d;
      frm_cnt_q   <= frm_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_flags_q <= err_flags_d;
    end
  end

  assign locked    = locked_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign frm_cnt   = frm_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign err_flags = err_flags_q;

endmodule

// File: tb/tb_autobus_checker.sv
// Bench for autobus_checker: an in-bench pattern generator feeds the DUT while a
// position-in-frame reference model predicts every output each cycle.
module tb_autobus_checker;

  logic        clk = 1'b0;
  logic        rst, clr, sop, eop, sof, eof, dav, rdy, locked;
  logic [15:0] sop_len, sof_len, dat, err_cnt;
  logic [1:0]  bp_mode;
  logic [31:0] pkt_cnt, frm_cnt;
  logic [4:0]  err_flags;

  always #5 clk = ~clk;

  autobus_checker dut (
    .clk(clk), .rst(rst), .sop_len(sop_len), .sof_len(sof_len), .bp_mode(bp_mode),
    .clr(clr), .sop(sop), .eop(eop), .sof(sof), .eof(eof), .dat(dat), .dav(dav),
    .rdy(rdy), .locked(locked), .pkt_cnt(pkt_cnt), .frm_cnt(frm_cnt),
    .err_cnt(err_cnt), .err_flags(err_flags)
  );

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: a frame is a flat run of beats; position m_pos picks every field.
  logic        m_rdy, m_locked;
  logic [15:0] m_lfsr, m_err;
  logic [31:0] m_pkt, m_frm;
  logic [4:0]  m_flags;
  int          m_pos, m_lp, m_lf;

  // Generator state
  int gpos = 0, glp = 1, glf = 1, inj = 0;
  int n_eops = 0, n_eofs = 0, n_fstart = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rdy",       64'(rdy),       64'(m_rdy));
      check("locked",    64'(locked),    64'(m_locked));
      check("pkt_cnt",   64'(pkt_cnt),   64'(m_pkt));
      check("frm_cnt",   64'(frm_cnt),   64'(m_frm));
      check("err_cnt",   64'(err_cnt),   64'(m_err));
      check("err_flags", 64'(err_flags), 64'(m_flags));
    end
  end

  task automatic model_step();
    logic beat, go;
    logic [4:0] e;
    int idx, pk;
    beat = dav && m_rdy;
    if (rst) begin
      m_rdy = 1'b0; m_lfsr = 16'hACE1; m_locked = 1'b0;
      m_pkt = '0; m_frm = '0; m_err = '0; m_flags = '0;
      m_pos = 0; m_lp = 1; m_lf = 1;
      return;
    end
    case (bp_mode)
      2'd0:    m_rdy = 1'b1;
      2'd1:    m_rdy = !m_rdy;
      2'd2:    m_rdy = m_lfsr[0];
      default: m_rdy = 1'b0;
    endcase
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    go = 1'b0;
    if (beat) begin
      if (!m_locked) begin
        if (sop && sof && sop_len != 0 && sof_len != 0) begin
          m_lp = int'(sop_len); m_lf = int'(sof_len); m_pos = 0; go = 1'b1;
        end
      end else begin
        go = 1'b1;
        if (m_pos == 0 && sop && sof) begin
          if (sop_len == 0 || sof_len == 0) begin
            m_locked = 1'b0; go = 1'b0;
          end else begin
            m_lp = int'(sop_len); m_lf = int'(sof_len);
          end
        end
      end
    end
    if (go) begin
      idx = m_pos % m_lp;
      pk  = m_pos / m_lp;
      e[0] = dat != 16'(idx);
      e[1] = sop != (idx == 0);
      e[2] = eop != (idx == m_lp - 1);
      e[3] = sof != (sop && pk == 0);
      e[4] = eof != (eop && pk == m_lf - 1);
      if (e != 5'd0) begin
        m_flags = m_flags | e;
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_locked = 1'b0;
      end else begin
        m_locked = 1'b1;
        if (eop) m_pkt = m_pkt + 32'd1;
        if (eof) m_frm = m_frm + 32'd1;
        m_pos = (m_pos + 1) % (m_lp * m_lf);
      end
    end
    if (clr) begin
      m_pkt = '0; m_frm = '0; m_err = '0; m_flags = '0;
    end
  endtask

  task automatic present();
    int plp, plf, idx;
    plp = (gpos == 0) ? int'(sop_len) : glp;
    plf = (gpos == 0) ? int'(sof_len) : glf;
    idx = gpos % plp;
    sop = (idx == 0);
    eop = (idx == plp - 1);
    sof = (gpos == 0);
    eof = (gpos == plp * plf - 1);
    dat = 16'(idx);
    case (inj)
      1: dat = (idx == 5) ? 16'd6 : 16'd5;
      2: sop = ~sop;
      3: eop = ~eop;
      4: sof = ~sof;
      5: eof = ~eof;
      default: ;
    endcase
  endtask

  task automatic gen_adv();
    if (gpos == 0) begin
      glp = int'(sop_len); glf = int'(sof_len); n_fstart++;
    end
    if (gpos % glp == glp - 1) n_eops++;
    if (gpos == glp * glf - 1) n_eofs++;
    gpos++;
    if (gpos == glp * glf) gpos = 0;
  endtask

  task automatic tick();
    logic bt;
    present();
    @(posedge clk);
    bt = !rst && dav && m_rdy;
    model_step();
    if (bt) gen_adv();
    @(negedge clk);
  endtask

  task automatic do_reset(input bit gen_too);
    rst = 1'b1; dav = 1'b0;
    tick(); tick();
    rst = 1'b0;
    if (gen_too) gpos = 0;
    chk_en = 1'b1;
  endtask

  task automatic run_to_gpos(input int target, input string name);
    int k;
    k = 0;
    while (gpos != target && k < 500) begin tick(); k++; end
    check(name, 64'(gpos), 64'(target));
  endtask

  int base;

  initial begin
    rst = 1'b1; clr = 1'b0; dav = 1'b0; bp_mode = 2'd0;
    sop_len = 16'd4; sof_len = 16'd3;
    @(negedge clk);
    do_reset(1'b1);
    check("reset_rdy",    64'(rdy), 64'd0);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_pkt",    64'(pkt_cnt), 64'd0);
    check("reset_errcnt", 64'(err_cnt), 64'd0);
    check("reset_flags",  64'(err_flags), 64'd0);

    // 1: continuous stream, 100 packets of 4 beats, 3 packets per frame
    n_eops = 0; n_eofs = 0; dav = 1'b1;
    for (int k = 0; k < 2000 && n_eops < 100; k++) tick();
    dav = 1'b0; tick(); tick();
    check("t1_eops",   64'(n_eops), 64'd100);
    check("t1_locked", 64'(locked), 64'd1);
    check("t1_pkt",    64'(pkt_cnt), 64'd100);
    check("t1_frm",    64'(frm_cnt), 64'd33);
    check("t1_flags",  64'(err_flags), 64'd0);

    // 2: LFSR then toggle backpressure, counts must follow generator eops
    clr = 1'b1; tick(); clr = 1'b0;
    n_eops = 0; n_eofs = 0; dav = 1'b1; bp_mode = 2'd2;
    for (int k = 0; k < 3000 && n_eops < 30; k++) tick();
    bp_mode = 2'd1;
    for (int k = 0; k < 3000 && n_eops < 60; k++) tick();
    dav = 1'b0; bp_mode = 2'd0; tick(); tick();
    check("t2_eops",   64'(n_eops), 64'd60);
    check("t2_pkt",    64'(pkt_cnt), 64'(n_eops));
    check("t2_frm",    64'(frm_cnt), 64'(n_eofs));
    check("t2_errcnt", 64'(err_cnt), 64'd0);

    // 3: single-beat packets and frames
    sop_len = 16'd1; sof_len = 16'd1;
    do_reset(1'b1);
    n_eops = 0; dav = 1'b1;
    for (int k = 0; k < 100 && n_eops < 10; k++) tick();
    dav = 1'b0; tick();
    check("t3_pkt",   64'(pkt_cnt), 64'd10);
    check("t3_frm",   64'(frm_cnt), 64'd10);
    check("t3_flags", 64'(err_flags), 64'd0);

    // 4: bad data on beat 2, then relock at next frame start
    sop_len = 16'd4; sof_len = 16'd3;
    do_reset(1'b1);
    dav = 1'b1;
    run_to_gpos(2, "t4_reach");
    inj = 1; tick(); inj = 0;
    dav = 1'b0; tick();
    check("t4_flags",  64'(err_flags), 64'd1);
    check("t4_errcnt", 64'(err_cnt), 64'd1);
    check("t4_locked", 64'(locked), 64'd0);
    base = n_fstart; dav = 1'b1;
    for (int k = 0; k < 200 && n_fstart == base; k++) tick();
    dav = 1'b0; tick();
    check("t4_relock", 64'(locked), 64'd1);

    // 5: missing eop on the last beat, then clr
    do_reset(1'b1);
    dav = 1'b1;
    run_to_gpos(3, "t5_reach");
    inj = 3; tick(); inj = 0;
    dav = 1'b0; tick();
    check("t5_flags",  64'(err_flags), 64'd4);
    check("t5_errcnt", 64'(err_cnt), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0; tick();
    check("t5_clr_flags",  64'(err_flags), 64'd0);
    check("t5_clr_errcnt", 64'(err_cnt), 64'd0);

    // 6: reset mid-packet, generator keeps going
    do_reset(1'b1);
    dav = 1'b1;
    run_to_gpos(2, "t6_reach");
    check("t6_locked_pre", 64'(locked), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick(); tick();
    check("t6_unlocked", 64'(locked), 64'd0);
    base = n_fstart;
    for (int k = 0; k < 200 && n_fstart == base; k++) tick();
    dav = 1'b0; tick();
    check("t6_relock", 64'(locked), 64'd1);
    check("t6_errcnt", 64'(err_cnt), 64'd0);

    // Randomized traffic, faults, clears, resets and backpressure changes
    do_reset(1'b1);
    for (int k = 0; k < 4000; k++) begin
      dav = ($urandom % 8) != 0;
      inj = ($urandom % 40 == 0) ? int'($urandom_range(1, 5)) : 0;
      clr = ($urandom % 150) == 0;
      rst = ($urandom % 1000) == 0;
      if ($urandom % 300 == 0) bp_mode = 2'($urandom % 4);
      if ($urandom % 200 == 0) begin
        sop_len = 16'($urandom_range(1, 5));
        sof_len = 16'($urandom_range(1, 4));
      end
      tick();
    end
    rst = 1'b0; clr = 1'b0; inj = 0; dav = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
